// File: rtl/pipe_result_collector.sv
// Result collector for the 3-stage arithmetic pipeline.
// Re-times issue valid, buffers F in a show-ahead FIFO, keeps sum and counts.
module pipe_result_collector #(
    parameter int DW      = 10,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4,
    parameter int ACC_W   = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [DW-1:0]    F_in,
    input  logic             clear,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full,
    output logic [ACC_W-1:0] acc,
    output logic             acc_sat,
    output logic [CNT_W-1:0] res_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [LATENCY-1:0] vsr;
    logic               v_al;
    logic [DW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        occ;
    logic               push;
    logic               pop;
    logic               drop;
    logic [ACC_W:0]     sum;

    assign v_al      = vsr[LATENCY-1];
    assign out_valid = (occ != '0);
    assign full      = (occ == (AW+1)'(DEPTH));
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = v_al & (~full | pop);
    assign drop      = v_al & full & ~pop;
    assign sum       = {1'b0, acc} + (ACC_W+1)'(F_in);

    // Valid delay line aligning issue to result arrival; clear leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsr <= '0;
        end else begin
            vsr <= (vsr << 1) | LATENCY'(in_valid);
        end
    end

    // FIFO storage written on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !clear) begin
            mem[wr_ptr] <= F_in;
        end
    end

    // FIFO pointers and occupancy; clear beats push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Saturating running sum and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (clear) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (push) begin
            if (sum[ACC_W]) begin
                acc     <= '1;
                acc_sat <= 1'b1;
            end else begin
                acc <= sum[ACC_W-1:0];
            end
        end
    end

    // Saturating accepted and dropped result counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt  <= '0;
            drop_cnt <= '0;
        end else if (clear) begin
            res_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (push && res_cnt != '1) begin
                res_cnt <= res_cnt + CNT_W'(1);
            end
            if (drop && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench for pipe_result_collector.
// Models the pipeline as a 3-deep delay of issued F values.
module tb_pipe_result_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [9:0]  F_in;
    logic        clear;
    logic [9:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        full;
    logic [15:0] acc;
    logic        acc_sat;
    logic [7:0]  res_cnt;
    logic [7:0]  drop_cnt;

    logic [9:0]  issue_val;
    logic [9:0]  fq [3];
    int          n_chk = 0;
    int          n_err = 0;

    pipe_result_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .F_in      (F_in),
        .clear     (clear),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .acc       (acc),
        .acc_sat   (acc_sat),
        .res_cnt   (res_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Pipeline model: value issued at edge k is F at edge k+3.
    always @(posedge clk) begin
        fq[0] <= issue_val;
        fq[1] <= fq[0];
        fq[2] <= fq[1];
    end
    assign F_in = fq[2];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic issue(input logic v, input logic [9:0] f);
        in_valid  = v;
        issue_val = f;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        issue_val = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_acc", acc, 0);
        chk("rst_cnt", res_cnt, 0);
        chk("rst_data", out_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: four back-to-back results drained at full rate
        out_ready = 1'b1;
        issue(1, 75);
        issue(1, 66);
        issue(1, 112);
        chk("t1_lat", out_valid, 0);
        issue(1, 62);
        chk("t1_v", out_valid, 1);
        chk("t1_d0", out_data, 75);
        tick();
        chk("t1_d1", out_data, 66);
        tick();
        chk("t1_d2", out_data, 112);
        tick();
        chk("t1_d3", out_data, 62);
        tick();
        chk("t1_empty", out_valid, 0);
        chk("t1_acc", acc, 315);
        chk("t1_cnt", res_cnt, 4);

        // 2: overflow with consumer stalled
        do_clear();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) issue(1, 10'(i));
        repeat (3) tick();
        chk("t2_full", full, 1);
        chk("t2_drop", drop_cnt, 2);
        chk("t2_cnt", res_cnt, 4);
        chk("t2_acc", acc, 10);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_drain", out_data, i);
            tick();
        end
        chk("t2_empty", out_valid, 0);

        // 3: push into a full FIFO while popping
        do_clear();
        chk("t3_drop0", drop_cnt, 0);
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) issue(1, 10'(i * 10));
        repeat (2) tick();
        chk("t3_full", full, 1);
        out_ready = 1'b1;
        tick();
        chk("t3_still", full, 1);
        chk("t3_drop", drop_cnt, 0);
        chk("t3_cnt", res_cnt, 5);
        chk("t3_head", out_data, 20);
        repeat (4) tick();
        chk("t3_empty", out_valid, 0);

        // 4: sum saturation
        do_clear();
        for (int i = 0; i < 64; i++) issue(1, 10'd1023);
        issue(1, 10'd28);
        repeat (3) tick();
        chk("t4_pre", acc, 65500);
        chk("t4_nosat", acc_sat, 0);
        issue(1, 10'd112);
        repeat (3) tick();
        chk("t4_clamp", acc, 65535);
        chk("t4_sat", acc_sat, 1);
        issue(1, 10'd5);
        repeat (3) tick();
        chk("t4_hold", acc, 65535);
        chk("t4_sticky", acc_sat, 1);
        chk("t4_cnt", res_cnt, 67);
        do_clear();
        chk("t4_clr", acc_sat, 0);

        // 5: clear with FIFO at 3 and two results in flight
        out_ready = 1'b0;
        issue(1, 10);
        issue(1, 20);
        issue(1, 30);
        issue(0, 0);
        issue(1, 40);
        issue(1, 50);
        chk("t5_pre", res_cnt, 3);
        do_clear();
        chk("t5_clr_v", out_valid, 0);
        chk("t5_clr_c", res_cnt, 0);
        chk("t5_clr_a", acc, 0);
        repeat (2) tick();
        chk("t5_cnt", res_cnt, 2);
        chk("t5_acc", acc, 90);
        chk("t5_head", out_data, 40);

        // 6: asynchronous reset mid-burst
        do_clear();
        for (int i = 1; i <= 4; i++) issue(1, 10'(i + 100));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_v", out_valid, 0);
        chk("t6_d", out_data, 0);
        chk("t6_acc", acc, 0);
        chk("t6_cnt", res_cnt, 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t6_stale", out_valid, 0);
        chk("t6_cnt2", res_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
